// File: rtl/fu_issue_sched_pkg.sv
// Shared definitions for the issue scheduler: class encodings and default sizing.
package fu_issue_sched_pkg;

   typedef enum logic [1:0] {
      ISS_ALU  = 2'd0,
      ISS_MEM  = 2'd1,
      ISS_MULT = 2'd2
   } iss_class_e;

   localparam int unsigned DEF_RS_SZ      = 16;
   localparam int unsigned DEF_RS_IDX     = 4;
   localparam int unsigned DEF_MULT_LAT   = 4;
   localparam int unsigned DEF_STARVE_LIM = 8;

endpackage

// File: rtl/fu_issue_sched_rr_pick.sv
// Rotating-priority picker: grants the first set req bit at or after ptr, wrapping modulo N.
module fu_issue_sched_rr_pick #(
   parameter int unsigned N   = 16,
   parameter int unsigned IDX = 4
) (
   input  logic [N-1:0]   req,
   input  logic [IDX-1:0] ptr,
   output logic [N-1:0]   gnt,
   output logic [IDX-1:0] idx,
   output logic           any
);

   int unsigned j;
   logic        found;

   always_comb begin
      gnt   = '0;
      idx   = '0;
      found = 1'b0;
      j     = 0;
      for (int i = 0; i < int'(N); i++) begin
         j = (32'(ptr) + 32'(i)) % N;
         if (!found && req[j]) begin
            found  = 1'b1;
            gnt[j] = 1'b1;
            idx    = IDX'(j);
         end
      end
   end

   assign any = |req;

endmodule

// File: rtl/fu_issue_sched.sv
// Issue scheduler: picks one ready RS entry per cycle, tracks FU occupancy and CDB slots.
module fu_issue_sched
   import fu_issue_sched_pkg::*;
#(
   parameter int unsigned RS_SZ      = DEF_RS_SZ,
   parameter int unsigned RS_IDX     = DEF_RS_IDX,
   parameter int unsigned MULT_LAT   = DEF_MULT_LAT,
   parameter int unsigned STARVE_LIM = DEF_STARVE_LIM
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [RS_SZ-1:0]    alu_rdy,
   input  logic [RS_SZ-1:0]    mem_rdy,
   input  logic [RS_SZ-1:0]    mult_rdy,
   input  logic                mem_done,
   input  logic                stall_ex,
   input  logic                flush,
   output logic [RS_SZ-1:0]    entry_sel,
   output logic                issue_valid,
   output logic [1:0]          issue_class,
   output logic [RS_IDX-1:0]   rs_idx_out,
   output logic                mem_busy,
   output logic [MULT_LAT-1:0] cdb_resv
);

   localparam int unsigned CNT_W = $clog2(STARVE_LIM + 1);

   logic [RS_IDX-1:0]   ptr_alu_q, ptr_alu_d, ptr_mem_q, ptr_mem_d, ptr_mult_q, ptr_mult_d;
   logic [MULT_LAT-1:0] resv_q, resv_d;
   logic                busy_q, busy_d;
   logic [CNT_W-1:0]    starve_q, starve_d;

   logic [RS_SZ-1:0]  alu_req, mem_req, mult_req;
   logic [RS_SZ-1:0]  alu_gnt, mem_gnt, mult_gnt;
   logic [RS_IDX-1:0] alu_idx, mem_idx, mult_idx;
   logic              alu_any, mem_any, mult_any;
   logic              grant_any;
   iss_class_e        grant_cls;
   logic [RS_SZ-1:0]  sel;

   // Ineligible classes are masked before picking so they never win arbitration.
   assign alu_req  = resv_q[0] ? '0 : alu_rdy;
   assign mult_req = resv_q[MULT_LAT-1] ? '0 : mult_rdy;
   assign mem_req  = (!busy_q || mem_done) ? mem_rdy : '0;

   fu_issue_sched_rr_pick #(.N(RS_SZ), .IDX(RS_IDX)) u_pick_alu (
      .req (alu_req),
      .ptr (ptr_alu_q),
      .gnt (alu_gnt),
      .idx (alu_idx),
      .any (alu_any)
   );

   fu_issue_sched_rr_pick #(.N(RS_SZ), .IDX(RS_IDX)) u_pick_mem (
      .req (mem_req),
      .ptr (ptr_mem_q),
      .gnt (mem_gnt),
      .idx (mem_idx),
      .any (mem_any)
   );

   fu_issue_sched_rr_pick #(.N(RS_SZ), .IDX(RS_IDX)) u_pick_mult (
      .req (mult_req),
      .ptr (ptr_mult_q),
      .gnt (mult_gnt),
      .idx (mult_idx),
      .any (mult_any)
   );

   always_comb begin
      grant_any = 1'b0;
      grant_cls = ISS_ALU;
      if (!stall_ex && !flush) begin
         if (starve_q == CNT_W'(STARVE_LIM) && alu_any) begin
            grant_any = 1'b1;
            grant_cls = ISS_ALU;
         end else if (mult_any) begin
            grant_any = 1'b1;
            grant_cls = ISS_MULT;
         end else if (mem_any) begin
            grant_any = 1'b1;
            grant_cls = ISS_MEM;
         end else if (alu_any) begin
            grant_any = 1'b1;
            grant_cls = ISS_ALU;
         end
      end
   end

   always_comb begin
      sel = '0;
      if (grant_any) begin
         case (grant_cls)
            ISS_MULT: sel = mult_gnt;
            ISS_MEM:  sel = mem_gnt;
            default:  sel = alu_gnt;
         endcase
      end
   end

   // Grant is dropped combinationally the moment reset asserts.
   assign entry_sel   = reset ? sel : '0;
   assign issue_valid = |entry_sel;
   assign issue_class = issue_valid ? grant_cls : ISS_ALU;
   assign mem_busy    = busy_q;
   assign cdb_resv    = resv_q;

   always_comb begin
      rs_idx_out = '0;
      for (int i = 0; i < int'(RS_SZ); i++) begin
         if (entry_sel[i]) rs_idx_out = RS_IDX'(i);
      end
   end

   always_comb begin
      ptr_alu_d  = ptr_alu_q;
      ptr_mem_d  = ptr_mem_q;
      ptr_mult_d = ptr_mult_q;
      if (grant_any) begin
         case (grant_cls)
            ISS_MULT: ptr_mult_d = (mult_idx == RS_IDX'(RS_SZ - 1)) ? '0 : mult_idx + 1'b1;
            ISS_MEM:  ptr_mem_d  = (mem_idx == RS_IDX'(RS_SZ - 1)) ? '0 : mem_idx + 1'b1;
            default:  ptr_alu_d  = (alu_idx == RS_IDX'(RS_SZ - 1)) ? '0 : alu_idx + 1'b1;
         endcase
      end

      resv_d = {1'b0, resv_q[MULT_LAT-1:1]};
      if (grant_any && grant_cls == ISS_MULT) resv_d[MULT_LAT-2] = 1'b1;

      busy_d = (grant_any && grant_cls == ISS_MEM) || (busy_q && !mem_done);

      starve_d = starve_q;
      if (!stall_ex) begin
         if (!alu_any || (grant_any && grant_cls == ISS_ALU)) begin
            starve_d = '0;
         end else if (starve_q != CNT_W'(STARVE_LIM)) begin
            starve_d = starve_q + 1'b1;
         end
      end

      if (flush) begin
         resv_d   = '0;
         busy_d   = 1'b0;
         starve_d = '0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ptr_alu_q  <= '0;
         ptr_mem_q  <= '0;
         ptr_mult_q <= '0;
         resv_q     <= '0;
         busy_q     <= 1'b0;
         starve_q   <= '0;
      end else begin
         ptr_alu_q  <= ptr_alu_d;
         ptr_mem_q  <= ptr_mem_d;
         ptr_mult_q <= ptr_mult_d;
         resv_q     <= resv_d;
         busy_q     <= busy_d;
         starve_q   <= starve_d;
      end
   end

endmodule

// File: tb/tb_fu_issue_sched.sv
// Directed bench for fu_issue_sched: expected grants are queued at drive time and checked in-cycle.
module tb_fu_issue_sched;

   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] alu_rdy, mem_rdy, mult_rdy;
   logic        mem_done, stall_ex, flush;
   logic [15:0] entry_sel;
   logic        issue_valid;
   logic [1:0]  issue_class;
   logic [3:0]  rs_idx_out;
   logic        mem_busy;
   logic [3:0]  cdb_resv;

   typedef struct packed {
      logic [15:0] sel;
      logic [1:0]  cls;
      logic [3:0]  idx;
   } exp_t;

   exp_t sb[$];
   int   nvec = 0;
   int   nmis = 0;

   always #5 clk = ~clk;

   fu_issue_sched dut (
      .clk         (clk),
      .reset       (reset),
      .alu_rdy     (alu_rdy),
      .mem_rdy     (mem_rdy),
      .mult_rdy    (mult_rdy),
      .mem_done    (mem_done),
      .stall_ex    (stall_ex),
      .flush       (flush),
      .entry_sel   (entry_sel),
      .issue_valid (issue_valid),
      .issue_class (issue_class),
      .rs_idx_out  (rs_idx_out),
      .mem_busy    (mem_busy),
      .cdb_resv    (cdb_resv)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nvec++;
      assert (obs === exp)
      else begin
         nmis++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic set_in(input logic [15:0] a, input logic [15:0] m, input logic [15:0] u,
                         input logic done, input logic stall, input logic fl);
      alu_rdy  = a;
      mem_rdy  = m;
      mult_rdy = u;
      mem_done = done;
      stall_ex = stall;
      flush    = fl;
   endtask

   task automatic push_grant(input int i, input logic [1:0] c);
      exp_t e;
      e.sel = 16'(1) << i;
      e.cls = c;
      e.idx = 4'(i);
      sb.push_back(e);
   endtask

   task automatic push_none();
      sb.push_back('0);
   endtask

   // Let inputs settle, then compare outputs against the oldest queued expectation.
   task automatic settle();
      exp_t e;
      #1;
      if (sb.size() == 0) begin
         nmis++;
         $error("FAIL scoreboard: observed empty queue expected an entry");
      end else begin
         e = sb.pop_front();
         chk("entry_sel", 32'(entry_sel), 32'(e.sel));
         chk("issue_valid", 32'(issue_valid), 32'(|e.sel));
         chk("issue_class", 32'(issue_class), 32'(e.cls));
         chk("rs_idx_out", 32'(rs_idx_out), 32'(e.idx));
      end
   endtask

   task automatic adv();
      @(negedge clk);
   endtask

   task automatic cycle();
      settle();
      adv();
   endtask

   initial begin
      // Reset holds every output low even with all ALU entries ready.
      reset = 1'b0;
      set_in(16'hFFFF, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
      push_none();
      settle();
      chk("reset_mem_busy", 32'(mem_busy), 32'd0);
      chk("reset_cdb_resv", 32'(cdb_resv), 32'd0);
      adv();
      reset = 1'b1;
      push_grant(0, 2'd0); cycle();
      push_grant(1, 2'd0); cycle();
      push_grant(2, 2'd0); cycle();

      // Round-robin wrap: park the ALU pointer at 15 first.
      set_in(16'h4000, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
      push_grant(14, 2'd0); cycle();
      set_in(16'h8001, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
      push_grant(15, 2'd0); cycle();
      push_grant(0, 2'd0);  cycle();
      push_grant(15, 2'd0); cycle();

      // MULT at t claims slot t+4, so ALU is blocked at t+3 and free at t+4.
      set_in(16'h0, 16'h0, 16'h0008, 1'b0, 1'b0, 1'b0);
      push_grant(3, 2'd2); cycle();
      set_in(16'h0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
      push_none(); settle(); chk("resv_t1", 32'(cdb_resv), 32'h4); adv();
      push_none(); settle(); chk("resv_t2", 32'(cdb_resv), 32'h2); adv();
      set_in(16'h0020, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
      push_none(); settle(); chk("resv_t3", 32'(cdb_resv), 32'h1); adv();
      push_grant(5, 2'd0); settle(); chk("resv_t4", 32'(cdb_resv), 32'h0); adv();

      // MEM occupancy and same-cycle reissue on mem_done.
      set_in(16'h0, 16'h0006, 16'h0, 1'b0, 1'b0, 1'b0);
      push_grant(1, 2'd1); cycle();
      set_in(16'h0, 16'h0004, 16'h0, 1'b0, 1'b0, 1'b0);
      push_none(); settle(); chk("mem_busy_held", 32'(mem_busy), 32'd1); adv();
      set_in(16'h0, 16'h0004, 16'h0, 1'b1, 1'b0, 1'b0);
      push_grant(2, 2'd1); cycle();
      set_in(16'h0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
      push_none(); settle(); chk("mem_busy_reissue", 32'(mem_busy), 32'd1); adv();
      set_in(16'h0, 16'h0, 16'h0, 1'b1, 1'b0, 1'b0);
      push_none(); cycle();
      set_in(16'h0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
      push_none(); settle(); chk("mem_busy_done", 32'(mem_busy), 32'd0); adv();

      // Starvation: MEM wins 8 times, then the guard hands ALU the slot.
      set_in(16'h0010, 16'h0008, 16'h0, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 8; i++) begin
         push_grant(3, 2'd1); cycle();
      end
      push_grant(4, 2'd0); cycle();
      push_grant(3, 2'd1); cycle();

      // Stall: no grant, ALU pointer holds at 5, mem_done still frees MEM.
      set_in(16'h0040, 16'h0, 16'h0, 1'b1, 1'b1, 1'b0);
      push_none(); cycle();
      set_in(16'h0060, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
      push_grant(5, 2'd0); settle(); chk("stall_mem_busy", 32'(mem_busy), 32'd0); adv();

      // Flush (with stall and mem_done also high) clears busy and reservations.
      set_in(16'h0, 16'h0010, 16'h0, 1'b0, 1'b0, 1'b0);
      push_grant(4, 2'd1); cycle();
      set_in(16'h0, 16'h0, 16'h0001, 1'b0, 1'b0, 1'b0);
      push_grant(0, 2'd2); cycle();
      set_in(16'h0001, 16'h0020, 16'h0, 1'b1, 1'b1, 1'b1);
      push_none(); settle();
      chk("pre_flush_busy", 32'(mem_busy), 32'd1);
      chk("pre_flush_resv", 32'(cdb_resv), 32'h4);
      adv();
      set_in(16'h0, 16'h0020, 16'h0, 1'b0, 1'b0, 1'b0);
      push_grant(5, 2'd1); settle();
      chk("post_flush_busy", 32'(mem_busy), 32'd0);
      chk("post_flush_resv", 32'(cdb_resv), 32'h0);
      adv();

      // Async reset mid-cycle drops the grant and state at once.
      set_in(16'hFFFF, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
      #2;
      reset = 1'b0;
      push_none(); settle();
      chk("async_rst_busy", 32'(mem_busy), 32'd0);
      chk("async_rst_resv", 32'(cdb_resv), 32'h0);
      adv();

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
      $finish;
   end

endmodule
